// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: memory-init freeze, load-use bubbles, branch flushes.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned INIT_CYCLES       = 4,
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_req,
  input  logic [4:0]  RsID,
  input  logic [4:0]  RtID,
  input  logic [4:0]  RtEX,
  input  logic        MemReadEX,
  input  logic        Branch,
  output logic        MemRst,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXBubble,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        EXMEMFlush,
  output logic [1:0]  ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(LOAD_STALL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hz;

  // Load in EX whose destination is read by the instruction in ID; $zero is exempt.
  assign hz = MemReadEX && (RtEX != 5'd0) && ((RtEX == RsID) || (RtEX == RtID));

  assign ctrl_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    MemRst     = 1'b0;
    PCWrite    = 1'b0;
    IFIDWrite  = 1'b0;
    IDEXBubble = 1'b0;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    EXMEMFlush = 1'b0;
    case (state)
      ST_INIT: begin
        MemRst     = 1'b1;
        IDEXBubble = 1'b1;
        if (cnt == INIT_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (Branch) begin
          IFIDFlush  = 1'b1;
          IDEXFlush  = 1'b1;
          EXMEMFlush = 1'b1;
          PCWrite    = 1'b1;
          IFIDWrite  = 1'b1;
        end else if (hz) begin
          IDEXBubble = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_nxt = ST_STALL;
            cnt_nxt   = CNT_W'(1);
          end
        end else if (init_req) begin
          PCWrite   = 1'b1;
          IFIDWrite = 1'b1;
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end else begin
          PCWrite   = 1'b1;
          IFIDWrite = 1'b1;
        end
      end
      ST_STALL: begin
        // A taken branch aborts the stall; the PC loads the branch target.
        if (Branch) begin
          IFIDFlush  = 1'b1;
          IDEXFlush  = 1'b1;
          EXMEMFlush = 1'b1;
          PCWrite    = 1'b1;
          IFIDWrite  = 1'b1;
          state_nxt  = ST_RUN;
          cnt_nxt    = '0;
        end else begin
          IDEXBubble = 1'b1;
          if (cnt == STALL_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters; INIT-phase bubbles are not counted as stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (IDEXBubble && (state != ST_INIT) && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
      if (IFIDFlush && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed stall/reset
// sequences and random stimulus against a counter-based reference model.
module tb_pipe_hazard_ctrl;

  // Output vector layout: {MemRst,PCWrite,IFIDWrite,IDEXBubble,IFIDFlush,IDEXFlush,EXMEMFlush,ctrl_state}
  localparam logic [8:0] E_INIT     = 9'b100100000;
  localparam logic [8:0] E_IDLE     = 9'b011000001;
  localparam logic [8:0] E_BUB_RUN  = 9'b000100001;
  localparam logic [8:0] E_BR_RUN   = 9'b011011101;
  localparam logic [8:0] E_STALL    = 9'b000100010;
  localparam logic [8:0] E_BR_STALL = 9'b011011110;
  localparam int INIT_N = 4;

  logic clk = 1'b0;
  logic rst_n, init_req, mrex, br;
  logic [4:0] rs, rt, rtex;

  logic m1, p1, i1, b1, ff1, df1, ef1;
  logic m3, p3, i3, b3, ff3, df3, ef3;
  logic [1:0] s1, s3;
  wire [8:0] out1 = {m1, p1, i1, b1, ff1, df1, ef1, s1};
  wire [8:0] out3 = {m3, p3, i3, b3, ff3, df3, ef3, s3};
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.INIT_CYCLES(INIT_N), .LOAD_STALL_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .RsID(rs), .RtID(rt), .RtEX(rtex),
    .MemReadEX(mrex), .Branch(br), .MemRst(m1), .PCWrite(p1), .IFIDWrite(i1),
    .IDEXBubble(b1), .IFIDFlush(ff1), .IDEXFlush(df1), .EXMEMFlush(ef1), .ctrl_state(s1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(sc1), .flush_count(fc1)
`endif
  );

  pipe_hazard_ctrl #(.INIT_CYCLES(INIT_N), .LOAD_STALL_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .RsID(rs), .RtID(rt), .RtEX(rtex),
    .MemReadEX(mrex), .Branch(br), .MemRst(m3), .PCWrite(p3), .IFIDWrite(i3),
    .IDEXBubble(b3), .IFIDFlush(ff3), .IDEXFlush(df3), .EXMEMFlush(ef3), .ctrl_state(s3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(sc3), .flush_count(fc3)
`endif
  );

  // Reference model: cycles of init left, bubble cycles still owed after the current one.
  int          m_il [2] = '{0, 0};
  int          m_sl [2] = '{0, 0};
  int unsigned m_sc [2] = '{0, 0};
  int unsigned m_fc [2] = '{0, 0};

  function automatic int lsc(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic hz_now();
    return mrex && (rtex != 5'd0) && ((rtex == rs) || (rtex == rt));
  endfunction

  function automatic logic [8:0] model_out(input int il, input int sl);
    if (il > 0) return E_INIT;
    if (sl > 0) return br ? E_BR_STALL : E_STALL;
    if (br) return E_BR_RUN;
    if (hz_now()) return E_BUB_RUN;
    return E_IDLE;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [8:0] o;
      o = model_out(m_il[k], m_sl[k]);
      if (!rst_n) begin
        m_il[k] = INIT_N; m_sl[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        if (o[5] && o[1:0] != 2'd0 && m_sc[k] != 32'hFFFF_FFFF) m_sc[k]++;
        if (o[4] && m_fc[k] != 32'hFFFF_FFFF) m_fc[k]++;
        if (m_il[k] > 0) m_il[k]--;
        else if (m_sl[k] > 0) m_sl[k] = br ? 0 : m_sl[k] - 1;
        else if (br) m_sl[k] = 0;
        else if (hz_now()) m_sl[k] = lsc(k) - 1;
        else if (init_req) m_il[k] = INIT_N;
      end
    end
  end

  typedef struct {
    logic       rst_n, init_req;
    logic [4:0] rs, rt, rtex;
    logic       mrex, br;
    logic [8:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic ir, input int a, input int b,
                              input int c, input logic mr, input logic bb, input logic [8:0] e);
    vec_t v;
    v.rst_n = r; v.init_req = ir; v.rs = 5'(a); v.rt = 5'(b); v.rtex = 5'(c);
    v.mrex = mr; v.br = bb; v.exp = e;
    return v;
  endfunction

  task automatic check9(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ir, input int a, input int b,
                       input int c, input logic mr, input logic bb);
    rst_n = r; init_req = ir; rs = 5'(a); rt = 5'(b); rtex = 5'(c); mrex = mr; br = bb;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic cyc3(input string name, input logic [8:0] exp);
    @(negedge clk);
    check9(name, out3, exp);
    @(posedge clk); #1;
  endtask

  vec_t tbl[20];

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, E_INIT);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, E_INIT);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, E_INIT);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, E_INIT);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0, E_IDLE);
    tbl[5]  = mk(1, 0, 5, 0, 5, 1, 0, E_BUB_RUN);
    tbl[6]  = mk(1, 0, 5, 0, 5, 0, 0, E_IDLE);
    tbl[7]  = mk(1, 0, 0, 0, 0, 1, 0, E_IDLE);
    tbl[8]  = mk(1, 0, 1, 7, 7, 1, 1, E_BR_RUN);
    tbl[9]  = mk(1, 0, 1, 7, 7, 1, 0, E_BUB_RUN);
    tbl[10] = mk(1, 0, 1, 7, 7, 1, 0, E_BUB_RUN);
    tbl[11] = mk(1, 1, 0, 0, 0, 0, 0, E_IDLE);
    tbl[12] = mk(1, 1, 0, 0, 0, 0, 0, E_INIT);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, E_INIT);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, E_INIT);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, E_INIT);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, E_IDLE);
    tbl[17] = mk(1, 0, 4, 5, 3, 1, 0, E_IDLE);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, E_IDLE);
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, E_INIT);

    drive(0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();

    // Vector table against the single-bubble instance
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst_n, tbl[i].init_req, int'(tbl[i].rs), int'(tbl[i].rt),
            int'(tbl[i].rtex), tbl[i].mrex, tbl[i].br);
      @(negedge clk);
      check9($sformatf("vec%0d", i), out1, tbl[i].exp);
      @(posedge clk); #1;
    end

    // Three-cycle stall instance: fresh reset, then full stall
    drive(0, 0, 0, 0, 0, 0, 0); cyc();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < INIT_N; i++) cyc3($sformatf("s3_init%0d", i), E_INIT);
    cyc3("s3_run", E_IDLE);
    drive(1, 0, 5, 0, 5, 1, 0); cyc3("s3_hz", E_BUB_RUN);
    drive(1, 0, 0, 0, 0, 0, 0); cyc3("s3_stall1", E_STALL);
    cyc3("s3_stall2", E_STALL);
    cyc3("s3_resume", E_IDLE);

    // Branch in the second bubble cycle aborts the stall
    drive(1, 0, 5, 0, 5, 1, 0); cyc3("s3_hz_b", E_BUB_RUN);
    drive(1, 0, 0, 0, 0, 0, 1); cyc3("s3_br_stall", E_BR_STALL);
    drive(1, 0, 0, 0, 0, 0, 0); cyc3("s3_after_br", E_IDLE);

    // Reset in STALL, then init request from RUN
    drive(1, 0, 5, 0, 5, 1, 0); cyc3("s3_hz_r", E_BUB_RUN);
    drive(0, 0, 0, 0, 0, 0, 0); cyc3("s3_rst_in_stall", E_STALL);
    drive(1, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    check32("stall_count_after_rst", sc3, 32'd0);
    check32("flush_count_after_rst", fc3, 32'd0);
`endif
    for (int i = 0; i < INIT_N; i++) cyc3($sformatf("s3_reinit%0d", i), E_INIT);
    cyc3("s3_run2", E_IDLE);
    drive(1, 1, 0, 0, 0, 0, 0); cyc3("s3_init_req", E_IDLE);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < INIT_N; i++) cyc3($sformatf("s3_reqinit%0d", i), E_INIT);
    cyc3("s3_run3", E_IDLE);

    // Random stimulus against the reference model, starting from a reset
    drive(0, 0, 0, 0, 0, 0, 0); cyc();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(63) != 0, $urandom_range(15) == 0,
            int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
            1'($urandom_range(1)), $urandom_range(7) == 0);
      @(negedge clk);
      check9($sformatf("rnd%0d_lsc1", n), out1, model_out(m_il[0], m_sl[0]));
      check9($sformatf("rnd%0d_lsc3", n), out3, model_out(m_il[1], m_sl[1]));
`ifdef HAZARD_PERF_CNT_EN
      check32($sformatf("rnd%0d_stall_cnt1", n), sc1, m_sc[0]);
      check32($sformatf("rnd%0d_flush_cnt1", n), fc1, m_fc[0]);
      check32($sformatf("rnd%0d_stall_cnt3", n), sc3, m_sc[1]);
      check32($sformatf("rnd%0d_flush_cnt3", n), fc3, m_fc[1]);
`endif
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
